// File: rtl/alu_iterative_if.sv
// Request/response bundle between operand select and the iterative ALU.
// The master drives the request and out_ready; the slave (ALU) drives the result side.
interface alu_iterative_if #(
   parameter int WIDTH = 32
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alu_op;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             busy;

   modport master (
      output start, a, b, alu_op, out_ready,
      input  in_ready, out_valid, result, zero, busy
   );

   modport slave (
      input  start, a, b, alu_op, out_ready,
      output in_ready, out_valid, result, zero, busy
   );
endinterface

// File: rtl/alu_iterative.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare ops plus iterative
// shift-add MUL and restoring DIVU/REMU, one bit per cycle.
module alu_iterative #(
   parameter int WIDTH = 32,
   parameter int SH_W  = 5
) (
   input logic            clk,
   input logic            reset,
   alu_iterative_if.slave bus
);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_OR   = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_SLL  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_SRL  = 4'h6;
   localparam logic [3:0] OP_SRA  = 4'h7;
   localparam logic [3:0] OP_SLT  = 4'h8;
   localparam logic [3:0] OP_SLTU = 4'h9;
   localparam logic [3:0] OP_MUL  = 4'hA;
   localparam logic [3:0] OP_DIVU = 4'hB;
   localparam logic [3:0] OP_REMU = 4'hC;

   typedef enum logic [1:0] {IDLE, MUL_IT, DIV_IT, DONE} state_t;

   state_t           r_state;
   logic [SH_W-1:0]  r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_div;
   logic             r_is_rem;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_out_valid;
   logic             r_busy;

   function automatic logic [WIDTH-1:0] f_single(input logic [3:0]       op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
      logic [SH_W-1:0]         sh;
      logic signed [WIDTH-1:0] xs;
      logic signed [WIDTH-1:0] ys;
      logic [WIDTH-1:0]        res;
      sh  = y[SH_W-1:0];
      xs  = x;
      ys  = y;
      res = '0;
      case (op)
         OP_ADD:  res = x + y;
         OP_OR:   res = x | y;
         OP_AND:  res = x & y;
         OP_SLL:  res = x << sh;
         OP_SUB:  res = x - y;
         OP_XOR:  res = x ^ y;
         OP_SRL:  res = x >> sh;
         OP_SRA:  res = xs >>> sh;
         OP_SLT:  res = {{(WIDTH-1){1'b0}}, (xs < ys)};
         OP_SLTU: res = {{(WIDTH-1){1'b0}}, (x < y)};
         default: res = '0;
      endcase
      return res;
   endfunction

   logic             w_in_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_single;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH:0]   w_rem_sub;
   logic             w_ge;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH-1:0] w_div_res;

   assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
   assign w_accept   = bus.start && w_in_ready;
   assign w_single   = f_single(bus.alu_op, bus.a, bus.b);

   assign w_acc_nxt  = r_mcand[0] ? (r_acc + r_mplier) : r_acc;

   // Restoring step: partial remainder needs one extra bit before the compare.
   assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
   assign w_rem_sub  = w_rem_sh - {1'b0, r_div};
   assign w_ge       = (w_rem_sh >= {1'b0, r_div});
   assign w_rem_nxt  = w_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
   assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_ge};
   assign w_div_res  = r_is_rem ? w_rem_nxt : w_quo_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_mcand     <= '0;
         r_mplier    <= '0;
         r_rem       <= '0;
         r_quo       <= '0;
         r_div       <= '0;
         r_is_rem    <= 1'b0;
         r_result    <= '0;
         r_zero      <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (w_accept) begin
                  case (bus.alu_op)
                     OP_MUL: begin
                        r_state     <= MUL_IT;
                        r_cnt       <= SH_W'(WIDTH-1);
                        r_acc       <= '0;
                        r_mcand     <= bus.a;
                        r_mplier    <= bus.b;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b1;
                     end
                     OP_DIVU, OP_REMU: begin
                        r_state     <= DIV_IT;
                        r_cnt       <= SH_W'(WIDTH-1);
                        r_rem       <= '0;
                        r_quo       <= bus.a;
                        r_div       <= bus.b;
                        r_is_rem    <= (bus.alu_op == OP_REMU);
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b1;
                     end
                     default: begin
                        r_state     <= DONE;
                        r_result    <= w_single;
                        r_zero      <= (w_single == '0);
                        r_out_valid <= 1'b1;
                     end
                  endcase
               end else if ((r_state == DONE) && bus.out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            MUL_IT: begin
               r_acc    <= w_acc_nxt;
               r_mcand  <= r_mcand >> 1;
               r_mplier <= r_mplier << 1;
               r_cnt    <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state     <= DONE;
                  r_result    <= w_acc_nxt;
                  r_zero      <= (w_acc_nxt == '0);
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            DIV_IT: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == '0) begin
                  r_state     <= DONE;
                  r_result    <= w_div_res;
                  r_zero      <= (w_div_res == '0);
                  r_out_valid <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.result    = r_result;
   assign bus.zero      = r_zero;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: hand-computed vectors, backpressure and mid-divide reset.
module tb_alu_iterative;

   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;

   alu_iterative_if #(.WIDTH(32)) bus ();

   alu_iterative #(.WIDTH(32), .SH_W(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Issue one request at posedge+1 and wait (bounded) for out_valid.
   task automatic run_op(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         output logic [31:0] res, output logic zz, output int lat,
                         output logic iter_ok);
      iter_ok    = 1'b1;
      bus.start  = 1'b1;
      bus.alu_op = op;
      bus.a      = aa;
      bus.b      = bb;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.a      = $urandom;
      bus.b      = $urandom;
      bus.alu_op = 4'h0;
      lat        = 1;
      while (!bus.out_valid && lat < 100) begin
         if (!(bus.busy === 1'b1 && bus.in_ready === 1'b0)) iter_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      res = bus.result;
      zz  = bus.zero;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[18];

   initial begin
      logic [31:0] res;
      logic [31:0] held;
      logic        zz;
      logic        ok;
      logic        stable;
      int          lat;
      int          exp_lat;

      n_total = 0;
      n_bad   = 0;
      vecs = '{
         '{4'h0, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0000_0006},
         '{4'h4, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
         '{4'h1, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF},
         '{4'h2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00},
         '{4'h3, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008},
         '{4'h5, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555},
         '{4'h7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000},
         '{4'h6, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000},
         '{4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
         '{4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
         '{4'hA, 32'h0000_1234, 32'h0000_0100, 32'h0012_3400},
         '{4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
         '{4'hB, 32'd100,       32'd7,         32'd14},
         '{4'hC, 32'd100,       32'd7,         32'd2},
         '{4'hB, 32'd12345,     32'd0,         32'hFFFF_FFFF},
         '{4'hC, 32'd9,         32'd0,         32'd9},
         '{4'hC, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F},
         '{4'hD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000}
      };

      reset         = 1'b1;
      bus.start     = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.alu_op    = 4'h0;
      bus.out_ready = 1'b1;
      #2;
      chk("rst_result", bus.result, 0);
      chk("rst_zero", bus.zero, 1);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      #10;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1);

      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, zz, lat, ok);
         exp_lat = (vecs[i].op inside {4'hA, 4'hB, 4'hC}) ? 33 : 1;
         chk($sformatf("v%0d_res", i), res, vecs[i].exp);
         chk($sformatf("v%0d_zero", i), zz, (vecs[i].exp == 0));
         chk($sformatf("v%0d_lat", i), lat, exp_lat);
         if (exp_lat == 33) chk($sformatf("v%0d_busy_stall", i), ok, 1);
      end

      // Backpressure: result must hold while out_ready is low.
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      run_op(4'hA, 32'd3, 32'd5, res, zz, lat, ok);
      chk("bp_mul_res", res, 15);
      chk("bp_mul_lat", lat, 33);
      held   = bus.result;
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (bus.result !== held || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
      end
      chk("bp_stable", stable, 1);
      bus.out_ready = 1'b1;
      #0;
      chk("bp_in_ready", bus.in_ready, 1);
      run_op(4'h0, 32'd1, 32'd1, res, zz, lat, ok);
      chk("b2b_res", res, 2);
      chk("b2b_lat", lat, 1);

      // Asynchronous reset in the middle of a divide.
      bus.start  = 1'b1;
      bus.alu_op = 4'hB;
      bus.a      = 32'd1000;
      bus.b      = 32'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk);
         #1;
      end
      chk("mid_busy", bus.busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_result", bus.result, 0);
      chk("arst_zero", bus.zero, 1);
      chk("arst_valid", bus.out_valid, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_in_ready", bus.in_ready, 1);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      run_op(4'h0, 32'd3, 32'd4, res, zz, lat, ok);
      chk("post_rst_res", res, 7);
      chk("post_rst_lat", lat, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
